// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide types, plus the arbiter FSM state and operation encodings.
package cpu_types_pkg;

   localparam int WORD_W = 32;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      IACC = 2'd1,
      DACC = 2'd2,
      RESP = 2'd3
   } arb_state_t;

   typedef enum logic [1:0] {
      IRD = 2'd0,
      DRD = 2'd1,
      DWR = 2'd2
   } arb_op_t;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one single-ported RAM between instruction fetch and data access.
// Requests are serialised, RAM controls held until ram_ready, hits pulse for one cycle.
module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int CNT_W = 32
)
(
   input  logic             CLK,
   input  logic             nRST,
   input  logic             halt,
   input  logic             iREN,
   input  word_t            iaddr,
   output word_t            iload,
   output logic             ihit,
   input  logic             dREN,
   input  logic             dWEN,
   input  word_t            daddr,
   input  word_t            dstore,
   output word_t            dload,
   output logic             dhit,
   output logic             ramREN,
   output logic             ramWEN,
   output word_t            ramaddr,
   output word_t            ramstore,
   input  word_t            ramload,
   input  logic             ram_ready,
   output logic [CNT_W-1:0] icount,
   output logic [CNT_W-1:0] dcount
);

   arb_state_t       state_q, state_d;
   arb_op_t          op_q, op_d;
   logic             last_d_q, last_d_d;
   word_t            addr_q, addr_d;
   word_t            store_q, store_d;
   word_t            load_q, load_d;
   logic [CNT_W-1:0] icount_q, icount_d;
   logic [CNT_W-1:0] dcount_q, dcount_d;

   logic i_pend;
   logic d_pend;
   logic grant_d;

   assign i_pend  = iREN & ~halt;
   assign d_pend  = dREN | dWEN;
   // On contention data wins unless it was the previous grant.
   assign grant_d = d_pend & (~i_pend | ~last_d_q);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q  <= IDLE;
         op_q     <= IRD;
         last_d_q <= 1'b0;
         addr_q   <= '0;
         store_q  <= '0;
         load_q   <= '0;
         icount_q <= '0;
         dcount_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         last_d_q <= last_d_d;
         addr_q   <= addr_d;
         store_q  <= store_d;
         load_q   <= load_d;
         icount_q <= icount_d;
         dcount_q <= dcount_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      last_d_d = last_d_q;
      addr_d   = addr_q;
      store_d  = store_q;
      load_d   = load_q;
      icount_d = icount_q;
      dcount_d = dcount_q;
      case (state_q)
         IDLE: begin
            if (grant_d) begin
               state_d  = DACC;
               last_d_d = 1'b1;
               addr_d   = daddr;
               store_d  = dstore;
               op_d     = dWEN ? DWR : DRD;
            end else if (i_pend) begin
               state_d  = IACC;
               last_d_d = 1'b0;
               addr_d   = iaddr;
               store_d  = dstore;
               op_d     = IRD;
            end
         end
         IACC, DACC: begin
            if (ram_ready) begin
               state_d = RESP;
               load_d  = ramload;
               if (op_q == IRD) begin
                  icount_d = icount_q + CNT_W'(1);
               end else begin
                  dcount_d = dcount_q + CNT_W'(1);
               end
            end
         end
         RESP: begin
            // Always return to IDLE so a stale held request is never re-sampled here.
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ihit     = 1'b0;
      dhit     = 1'b0;
      ramaddr  = addr_q;
      ramstore = store_q;
      iload    = load_q;
      dload    = load_q;
      icount   = icount_q;
      dcount   = dcount_q;
      case (state_q)
         IACC, DACC: begin
            ramREN = (op_q != DWR);
            ramWEN = (op_q == DWR);
         end
         RESP: begin
            ihit = (op_q == IRD);
            dhit = (op_q != IRD);
         end
         default: begin
         end
      endcase
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter and sequencer sharing one single-ported RAM between the pipeline's instruction-fetch and data-access request streams. It sits between `datapath_cache_if` (iREN/dREN/dWEN, addresses, store data) and the RAM. It serialises requests, holds RAM controls stable until the RAM reports ready, and returns one-cycle `ihit`/`dhit` pulses with registered load data. It also keeps completed-access counters for performance debug.

## Interface
Parameters:
- `CNT_W`, default 32: width of the access counters.

Ports:
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `halt`  in  1  processor halted; new instruction requests are ignored.
- `iREN`  in  1  instruction read request; held until `ihit`.
- `iaddr`  in  32  instruction address (word_t).
- `iload`  out  32  instruction read data; valid while `ihit`.
- `ihit`  out  1  one-cycle completion pulse for instruction access.
- `dREN`  in  1  data read request; held until `dhit`.
- `dWEN`  in  1  data write request; held until `dhit`.
- `daddr`  in  32  data address.
- `dstore`  in  32  data write value.
- `dload`  out  32  data read data; valid while `dhit`.
- `dhit`  out  1  one-cycle completion pulse for data access.
- `ramREN`  out  1  RAM read strobe.
- `ramWEN`  out  1  RAM write strobe.
- `ramaddr`  out  32  RAM address.
- `ramstore`  out  32  RAM write data.
- `ramload`  in  32  RAM read data; valid when `ram_ready`.
- `ram_ready`  in  1  RAM has completed the current access.
- `icount`  out  CNT_W  completed instruction accesses.
- `dcount`  out  CNT_W  completed data accesses.

## Operation
- FSM states:
  - IDLE: sample requests, no RAM strobes.
  - IACC: RAM instruction read in progress.
  - DACC: RAM data read or write in progress.
  - RESP: hit pulse issued, no request sampling.
- Pending conditions:
  - Instruction pending = `iREN & ~halt`.
  - Data pending = `dREN | dWEN`.
- IDLE grant rules:
  - Only one pending: grant it.
  - Both pending: grant the one not granted last (`last_d` flag). Data wins first after reset.
  - Neither pending: stay IDLE.
- On grant, the edge latches:
  - `addr_q` ← iaddr or daddr.
  - `store_q` ← dstore.
  - `op_q` ∈ {IRD, DRD, DWR}; `dREN & dWEN` together is treated as DWR.
  - Then move to IACC or DACC and update `last_d`.
- IACC/DACC:
  - `ramaddr` = addr_q, `ramstore` = store_q.
  - `ramREN` = (op_q != DWR), `ramWEN` = (op_q == DWR).
  - All four are held constant until `ram_ready`.
- `ram_ready` seen in IACC/DACC:
  - Capture `ramload` into `load_q` (also for writes; the value is ignored).
  - Go to RESP.
  - Increment `icount` or `dcount`; counters wrap modulo 2^CNT_W.
- RESP:
  - `ihit` = (op_q == IRD), `dhit` = (op_q != IRD).
  - `iload` and `dload` both present `load_q`.
  - RAM strobes low.
  - Next state IDLE.
- A request that drops during IACC/DACC does not abort the access. It completes and its hit pulse is still issued; requesters ignore unsolicited hits.
- `halt` rising during IACC does not abort the instruction access. `halt` has no effect on data requests.
- Request inputs are ignored outside IDLE.

## Timing
- Reset (async, nRST low) values:
  - State IDLE, `last_d` = 0.
  - addr_q, store_q, load_q = 0; op_q = IRD.
  - All strobes, `ihit`, `dhit` = 0.
  - `iload`, `dload` = 0; `icount`, `dcount` = 0.
- Reset asserted mid-access drops the access immediately. No hit is issued; the RAM sees its strobes fall asynchronously.
- Latency, request seen in IDLE at cycle 0:
  - Strobes are high from cycle 1.
  - `ram_ready` at cycle 1+W (W ≥ 0 wait cycles).
  - Hit in cycle 2+W; IDLE in cycle 3+W.
  - Minimum 3 cycles per access, back-to-back.
- The hit pulse is exactly one cycle.
- The requester may change address or request in the cycle after the hit. RESP guarantees a stale held request is never re-sampled.
- `ram_ready` outside IACC/DACC is ignored.

## Structure
- Shared `cpu_types_pkg` supplies `word_t`.
- Add to the package:
  - `arb_state_t` enum {IDLE, IACC, DACC, RESP}.
  - `arb_op_t` enum {IRD, DRD, DWR}.
- No sub-module: a single flat module with one state register block, one next-state block and an output-decode block.

## Test plan
- Single instruction read: iREN=1, iaddr=0x40, ram_ready on the first IACC cycle, ramload=0x8C220004. Required: ramREN=1 with ramaddr=0x40 for 1 cycle; ihit=1 with iload=0x8C220004 in cycle 2; icount=1.
- Data write with 2 wait states: dWEN=1, daddr=0x100, dstore=0xDEADBEEF. Required: ramWEN held with stable addr/data for 3 cycles; dhit in cycle 4; ramREN never high; dcount=1.
- Contention: iREN and dREN held continuously from reset, ram_ready always 1. Required: grants alternate D,I,D,I; each completes every 3 cycles; after 12 cycles icount=2, dcount=2.
- Halt: halt=1 with iREN=1. Required: no RAM strobe and no ihit for 10 cycles. dREN asserted in that window is still served with dhit.
- Reset mid-access: nRST low during DACC. Required: ramWEN/ramREN fall in the same cycle; no dhit; all outputs at reset values. After release, a fresh iREN completes normally.
- Dropped request: dREN deasserted during DACC with ram_ready delayed 3 cycles. Required: access still completes, dhit pulses once, FSM returns to IDLE.
